// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stage sequencer: FSM state encoding,
// default transform size and a constant-foldable clog2.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LOG_N_DEF = 4;
  localparam int N         = 1 << LOG_N_DEF;
  localparam int HALF_N    = N / 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_addr_gen.sv
// Combinational map from (stage, butterfly index) to the in-place DIT
// operand pair and the twiddle ROM index.
module ntt_addr_gen #(
  parameter int LOG_N = 4,
  parameter int SW    = 2
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG_N-2:0] j,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0] tw_idx
);

  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] jx;
  logic [LOG_N-1:0] group;
  logic [LOG_N-1:0] offset;

  always_comb begin
    half   = LOG_N'(1) << stage;
    jx     = {1'b0, j};
    group  = jx >> stage;
    offset = jx & (half - LOG_N'(1));
    addr_a = ((group << stage) << 1) | offset;
    addr_b = addr_a | half;
    // offset < 2**stage, so it always fits in LOG_N-1 bits before scaling
    tw_idx = offset[LOG_N-2:0] << (LOG_N - 1 - int'(stage));
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Stage/butterfly sequencer for the radix-2 in-place DIT NTT core; state
// advances on the falling clock edge to match the datapath library.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int LOG_N  = LOG_N_DEF,
  parameter int BF_LAT = 3,
  localparam int SW    = (clog2(LOG_N) < 1) ? 1 : clog2(LOG_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0] tw_idx,
  output logic             tw_inv,
  output logic [SW-1:0]    stage
);

  localparam int              JW         = LOG_N - 1;
  localparam logic [JW-1:0]   J_LAST     = '1;
  localparam logic [SW-1:0]   STAGE_LAST = SW'(LOG_N - 1);
  localparam logic [3:0]      DRAIN_INIT = 4'(BF_LAT - 1);

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [SW-1:0]    stage_d;
  logic [3:0]       drain_q, drain_d;
  logic             inv_d;
  logic [LOG_N-1:0] gen_a, gen_b;
  logic [JW-1:0]    gen_tw;

  // Addresses are generated from the next-state indices so they can be
  // registered and line up with the cycle in which the FSM sits in RUN.
  ntt_addr_gen #(
    .LOG_N (LOG_N),
    .SW    (SW)
  ) u_addr_gen (
    .stage  (stage_d),
    .j      (j_d),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage;
    drain_d = drain_q;
    inv_d   = tw_inv;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          j_d     = '0;
          stage_d = '0;
          inv_d   = inv;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) begin
          if (stage == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage + SW'(1);
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        j_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      stage   <= '0;
      drain_q <= '0;
      tw_inv  <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_idx  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage   <= stage_d;
      drain_q <= drain_d;
      tw_inv  <= inv_d;
      if (state_d == ST_RUN) begin
        addr_a <= gen_a;
        addr_b <= gen_b;
        tw_idx <= gen_tw;
      end else begin
        addr_a <= '0;
        addr_b <= '0;
        tw_idx <= '0;
      end
    end
  end

  // Stall gates issue within the same cycle; the operands stay presented.
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign bf_valid = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: directed timeline tables plus randomized
// stall/start traffic compared against a transform-level reference model.
module tb_ntt_stage_sequencer;
  import ntt_pkg::*;

  localparam int LOG_N  = LOG_N_DEF;
  localparam int BF_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       inv = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, bf_valid, tw_inv;
  logic [3:0] addr_a, addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: phase 0 idle, 1 issuing, 2 draining, 3 done
  int   m_ph = 0, m_s = 0, m_k = 0, m_d = 0;
  logic m_inv = 1'b0;

  ntt_stage_sequencer #(.LOG_N(LOG_N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .stall(stall),
    .busy(busy), .done(done), .bf_valid(bf_valid), .addr_a(addr_a),
    .addr_b(addr_b), .tw_idx(tw_idx), .tw_inv(tw_inv), .stage(stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic stall;
    logic v;
    logic busy;
    int   a;
    int   b;
    int   tw;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k-th address with bit s clear, its partner, and its twiddle index
  task automatic pair(input int s, input int k, output int a, output int b, output int tw);
    int hf, cnt;
    bit found;
    hf = 1 << s;
    cnt = 0;
    found = 0;
    a = 0;
    for (int x = 0; x < N; x++) begin
      if ((x & hf) == 0 && !found) begin
        if (cnt == k) begin
          a = x;
          found = 1;
        end
        cnt++;
      end
    end
    b  = a + hf;
    tw = (a % hf) * (HALF_N / hf);
  endtask

  task automatic model_step();
    if (!rst) begin
      m_ph = 0; m_s = 0; m_k = 0; m_d = 0; m_inv = 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin m_ph = 1; m_s = 0; m_k = 0; m_inv = inv; end
        1: if (!stall) begin
             if (m_k == HALF_N - 1) begin m_ph = 2; m_d = BF_LAT; end
             else m_k++;
           end
        2: begin
             m_d--;
             if (m_d == 0) begin
               if (m_s == LOG_N - 1) m_ph = 3;
               else begin m_ph = 1; m_s++; m_k = 0; end
             end
           end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic model_check();
    int ea, eb, et;
    chk("bf_valid", bf_valid, (m_ph == 1) && !stall);
    chk("busy", busy, (m_ph == 1) || (m_ph == 2));
    chk("done", done, m_ph == 3);
    chk("tw_inv", tw_inv, m_inv);
    if (m_ph == 1) begin
      pair(m_s, m_k, ea, eb, et);
      chk("addr_a", addr_a, ea);
      chk("addr_b", addr_b, eb);
      chk("tw_idx", tw_idx, et);
      chk("stage", stage, m_s);
    end else if (m_ph == 0) begin
      chk("idle_addr", {addr_a, addr_b, tw_idx}, 0);
      chk("idle_stage", stage, 0);
    end
  endtask

  // one clock cycle: inputs set just after the active (falling) edge,
  // outputs sampled on the rising edge in the middle of the cycle
  task automatic cyc(input logic s_start, input logic s_inv, input logic s_stall, input logic s_rst);
    @(negedge clk);
    model_step();
    #1;
    start = s_start;
    inv   = s_inv;
    stall = s_stall;
    rst   = s_rst;
    @(posedge clk);
    model_check();
  endtask

  initial begin
    int dn, dc, bfc, inv_bad;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0,  0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0,  1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1,  2,  3, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1,  4,  5, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1,  6,  7, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1,  8,  9, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 11, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12, 13, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 14, 15, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0};

    // power-on reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("por_outputs", {bf_valid, busy, done, addr_a, addr_b, tw_idx, tw_inv, stage}, 0);

    // plain run: stage 0 table, stage 3 addresses, completion timing
    bfc = 0; dn = 0; dc = -1;
    for (int r = 0; r < 12; r++) begin
      cyc(tbl[r].start, 1'b0, tbl[r].stall, 1'b1);
      chk("s0_valid", bf_valid, tbl[r].v);
      chk("s0_busy", busy, tbl[r].busy);
      if (tbl[r].a >= 0) begin
        chk("s0_addr_a", addr_a, tbl[r].a);
        chk("s0_addr_b", addr_b, tbl[r].b);
        chk("s0_tw", tw_idx, tbl[r].tw);
      end
      bfc += int'(bf_valid);
    end
    for (int c = 12; c < 52; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      bfc += int'(bf_valid);
      if (c >= 34 && c <= 41) begin
        chk("s3_addr_a", addr_a, c - 34);
        chk("s3_addr_b", addr_b, c - 26);
        chk("s3_tw", tw_idx, c - 34);
        chk("s3_stage", stage, 3);
      end
      if (c == 44) chk("busy_before_done", busy, 1);
      if (c == 45) chk("busy_at_done", busy, 0);
      if (done) begin dn++; dc = c; end
    end
    chk("done_cycle", dc, 45);
    chk("done_count", dn, 1);
    chk("bf_total", bfc, 32);

    // inverse run with a 4-cycle stall at stage 1, j=2 and a stray start
    dn = 0; dc = -1; inv_bad = 0;
    for (int c = 0; c < 60; c++) begin
      cyc((c == 0) || (c == 20), 1'b1, (c >= 14) && (c <= 17), 1'b1);
      if (c >= 14 && c <= 17) begin
        chk("stall_valid", bf_valid, 0);
        chk("stall_addr_a", addr_a, 4);
        chk("stall_addr_b", addr_b, 6);
      end
      if (c == 18) begin
        chk("unstall_valid", bf_valid, 1);
        chk("unstall_addr_a", addr_a, 4);
      end
      if (c >= 1 && c <= 49 && tw_inv !== 1'b1) inv_bad++;
      if (done) begin dn++; dc = c; end
    end
    chk("stall_done_cycle", dc, 49);
    chk("stall_done_count", dn, 1);
    chk("inv_held", inv_bad, 0);
    chk("inv_after_done", tw_inv, 1);

    // reset held 3 cycles inside stage 2, then restart
    dn = 0; dc = -1;
    for (int c = 0; c < 81; c++) begin
      cyc((c == 0) || (c == 28), c == 0, 1'b0, !(c >= 25 && c <= 27));
      if (c == 25) chk("pre_rst_stage", stage, 2);
      if (c == 28)
        chk("rst_outputs", {bf_valid, busy, done, addr_a, addr_b, tw_idx, tw_inv, stage}, 0);
      if (c == 29) begin
        chk("restart_valid", bf_valid, 1);
        chk("restart_addr", {addr_a, addr_b}, 8'h01);
        chk("restart_stage", stage, 0);
      end
      if (done) begin dn++; dc = c; end
    end
    chk("rst_done_cycle", dc, 73);
    chk("rst_done_count", dn, 1);

    // randomized stall, direction and stray start traffic
    for (int run = 0; run < 6; run++) begin
      for (int c = 0; c < 100; c++) begin
        cyc((c == 0) || ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
